// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM port among PORTS requesters.
// The ROM's registered output doubles as the single-entry response buffer.
module rom_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4096,
  parameter int PORTS = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PORTS-1:0]    req_valid,
  input  logic [PORTS*AW-1:0] req_addr,
  output logic [PORTS-1:0]    req_ready,
  output logic [PORTS-1:0]    rsp_valid,
  output logic [WIDTH-1:0]    rsp_data,
  input  logic [PORTS-1:0]    rsp_ready,
  output logic                rom_en,
  output logic [AW-1:0]       rom_addr,
  input  logic [WIDTH-1:0]    rom_data
);

  localparam int PW = $clog2(PORTS);

  typedef enum logic {
    S_IDLE,
    S_PEND
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_owner, w_owner_nxt;
  logic [PW-1:0] r_ptr,   w_ptr_nxt;

  logic [PW-1:0] w_gnt;
  logic          w_found;
  logic          w_free;
  logic          w_issue;
  logic          w_consume;

  // Search upward from r_ptr, wrapping explicitly so PORTS need not be a power of two.
  always_comb begin
    int unsigned idx;
    w_found = 1'b0;
    w_gnt   = '0;
    idx     = 0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      idx = 32'(r_ptr) + k;
      if (idx >= PORTS) idx = idx - PORTS;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_gnt   = PW'(idx);
      end
    end
  end

  always_comb begin
    w_consume = (r_state == S_PEND) && rsp_ready[r_owner];
    w_free    = (r_state == S_IDLE) || rsp_ready[r_owner];
    w_issue   = !rst && w_free && w_found;

    rom_en    = w_issue;
    rom_addr  = w_issue ? req_addr[int'(w_gnt)*AW +: AW] : '0;
    rsp_data  = rom_data;

    req_ready = '0;
    rsp_valid = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      req_ready[i] = w_issue && (w_gnt == PW'(i));
      rsp_valid[i] = (r_state == S_PEND) && (r_owner == PW'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    if (w_issue) begin
      w_state_nxt = S_PEND;
      w_owner_nxt = w_gnt;
      w_ptr_nxt   = (w_gnt == PW'(PORTS - 1)) ? '0 : w_gnt + PW'(1);
    end else if (w_consume) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: 4-port instance plus a 3-port instance,
// each backed by a behavioural ROM with mem[a] = a[7:0] ^ 8'hA5.
module tb_rom_arbiter;

  localparam int AW = 12;

  logic            clk = 1'b0;
  logic            rst;
  int              n_checks = 0;
  int              n_errors = 0;

  // 4-port instance
  logic [3:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [4*AW-1:0] req_addr;
  logic [7:0]      rsp_data;
  logic            rom_en;
  logic [AW-1:0]   rom_addr;
  logic [7:0]      rom_data = '0;

  // 3-port instance
  logic [2:0]      req_valid3, req_ready3, rsp_valid3, rsp_ready3;
  logic [3*AW-1:0] req_addr3;
  logic [7:0]      rsp_data3;
  logic            rom_en3;
  logic [AW-1:0]   rom_addr3;
  logic [7:0]      rom_data3 = '0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en)  rom_data  <= rom_addr[7:0]  ^ 8'hA5;
  always @(posedge clk) if (rom_en3) rom_data3 <= rom_addr3[7:0] ^ 8'hA5;

  rom_arbiter #(.WIDTH(8), .DEPTH(4096), .PORTS(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  rom_arbiter #(.WIDTH(8), .DEPTH(4096), .PORTS(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid3), .req_addr(req_addr3), .req_ready(req_ready3),
    .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .rsp_ready(rsp_ready3),
    .rom_en(rom_en3), .rom_addr(rom_addr3), .rom_data(rom_data3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = '0; req_addr = '0; rsp_ready = '0;
    req_valid3 = '0; req_addr3 = '0; rsp_ready3 = '0;
    tick; tick;
    n_checks++;
    if (rsp_valid !== 4'b0000) begin n_errors++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    req_valid = 4'b1111; rsp_ready = 4'b1111;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    n_checks++;
    if (rom_en !== 1'b0) begin n_errors++; $display("FAIL reset_rom_en got=%b exp=0", rom_en); end
    tick;
    n_checks++;
    if (rsp_valid !== 4'b0000) begin n_errors++; $display("FAIL reset_no_accept got=%b exp=0000", rsp_valid); end
    req_valid = '0; rsp_ready = '0;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single;
    req_valid = 4'b0100; req_addr[2*AW +: AW] = 12'h010; rsp_ready = 4'b1111;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL single_req_ready got=%b exp=0100", req_ready); end
    n_checks++;
    if (rom_en !== 1'b1 || rom_addr !== 12'h010) begin
      n_errors++; $display("FAIL single_rom got en=%b addr=%h exp en=1 addr=010", rom_en, rom_addr);
    end
    tick;
    req_valid = '0;
    #1;
    n_checks++;
    if (rsp_valid !== 4'b0100 || rsp_data !== 8'hB5) begin
      n_errors++; $display("FAIL single_rsp got v=%b d=%h exp v=0100 d=b5", rsp_valid, rsp_data);
    end
    tick;
    n_checks++;
    if (rsp_valid !== 4'b0000) begin n_errors++; $display("FAIL single_done got=%b exp=0000", rsp_valid); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_d;
    rsp_ready = 4'b1111;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin req_valid = 4'b0001; req_addr[0 +: AW] = AW'(i); end
      else       req_valid = '0;
      #1;
      if (i > 0) begin
        exp_d = 8'(i - 1) ^ 8'hA5;
        n_checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== exp_d) begin
          n_errors++; $display("FAIL stream_rsp[%0d] got v=%b d=%h exp v=0001 d=%h", i - 1, rsp_valid, rsp_data, exp_d);
        end
      end
      if (i < 8) begin
        n_checks++;
        if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL stream_req_ready[%0d] got=%b exp=0001", i, req_ready); end
      end
      tick;
    end
    n_checks++;
    if (rsp_valid !== 4'b0000) begin n_errors++; $display("FAIL stream_done got=%b exp=0000", rsp_valid); end
  endtask

  task automatic test_fairness;
    logic [3:0] exp_g, exp_v;
    logic [7:0] exp_d;
    rst = 1'b1; tick; rst = 1'b0;
    for (int p = 0; p < 4; p++) req_addr[p*AW +: AW] = 12'h100 + AW'(p);
    req_valid = 4'b1111; rsp_ready = 4'b1111;
    for (int k = 0; k <= 8; k++) begin
      #1;
      exp_g = 4'b0001 << (k % 4);
      n_checks++;
      if (req_ready !== exp_g || rom_addr !== (12'h100 + AW'(k % 4))) begin
        n_errors++; $display("FAIL fair_grant[%0d] got g=%b a=%h exp g=%b", k, req_ready, rom_addr, exp_g);
      end
      if (k > 0) begin
        exp_v = 4'b0001 << ((k - 1) % 4);
        exp_d = 8'((k - 1) % 4) ^ 8'hA5;
        n_checks++;
        if (rsp_valid !== exp_v || rsp_data !== exp_d) begin
          n_errors++; $display("FAIL fair_rsp[%0d] got v=%b d=%h exp v=%b d=%h", k, rsp_valid, rsp_data, exp_v, exp_d);
        end
      end
      tick;
    end
    req_valid = '0;
    #1;
    n_checks++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 8'hA5) begin
      n_errors++; $display("FAIL fair_last got v=%b d=%h exp v=0001 d=a5", rsp_valid, rsp_data);
    end
    tick;
  endtask

  task automatic test_backpressure;
    req_valid = 4'b0010; req_addr[1*AW +: AW] = 12'h0FF; rsp_ready = 4'b0000;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL bp_req_ready got=%b exp=0010", req_ready); end
    tick;
    req_valid = 4'b1000; req_addr[3*AW +: AW] = 12'h033;
    rsp_ready = 4'b1101;  // every port except the owner
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (rsp_valid !== 4'b0010 || rsp_data !== 8'h5A || rom_en !== 1'b0 || req_ready !== 4'b0000) begin
        n_errors++;
        $display("FAIL bp_hold[%0d] got v=%b d=%h en=%b rr=%b exp v=0010 d=5a en=0 rr=0000",
                 c, rsp_valid, rsp_data, rom_en, req_ready);
      end
      tick;
    end
    rsp_ready = 4'b1111;
    #1;
    n_checks++;
    if (req_ready !== 4'b1000 || rom_en !== 1'b1 || rom_addr !== 12'h033 || rsp_valid !== 4'b0010) begin
      n_errors++;
      $display("FAIL bp_release got rr=%b en=%b a=%h v=%b exp rr=1000 en=1 a=033 v=0010",
               req_ready, rom_en, rom_addr, rsp_valid);
    end
    tick;
    req_valid = '0;
    #1;
    n_checks++;
    if (rsp_valid !== 4'b1000 || rsp_data !== 8'h96) begin
      n_errors++; $display("FAIL bp_next got v=%b d=%h exp v=1000 d=96", rsp_valid, rsp_data);
    end
    tick;
    n_checks++;
    if (rsp_valid !== 4'b0000) begin n_errors++; $display("FAIL bp_done got=%b exp=0000", rsp_valid); end
  endtask

  task automatic test_reset_mid;
    req_valid = 4'b0001; req_addr[0 +: AW] = 12'h020; rsp_ready = 4'b0000;
    tick;
    req_valid = '0;
    #1;
    n_checks++;
    if (rsp_valid !== 4'b0001) begin n_errors++; $display("FAIL rmid_pending got=%b exp=0001", rsp_valid); end
    rst = 1'b1; req_valid = 4'b0101; req_addr[2*AW +: AW] = 12'h040;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000 || rom_en !== 1'b0) begin
      n_errors++; $display("FAIL rmid_in_reset got rr=%b en=%b exp rr=0000 en=0", req_ready, rom_en);
    end
    tick;
    n_checks++;
    if (rsp_valid !== 4'b0000) begin n_errors++; $display("FAIL rmid_dropped got=%b exp=0000", rsp_valid); end
    rst = 1'b0; rsp_ready = 4'b1111;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001 || rom_addr !== 12'h020) begin
      n_errors++; $display("FAIL rmid_ptr0 got rr=%b a=%h exp rr=0001 a=020", req_ready, rom_addr);
    end
    tick;
    req_valid = 4'b0100;
    #1;
    n_checks++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 8'h85 || req_ready !== 4'b0100) begin
      n_errors++; $display("FAIL rmid_rsp0 got v=%b d=%h rr=%b exp v=0001 d=85 rr=0100", rsp_valid, rsp_data, req_ready);
    end
    tick;
    req_valid = '0;
    #1;
    n_checks++;
    if (rsp_valid !== 4'b0100 || rsp_data !== 8'hE5) begin
      n_errors++; $display("FAIL rmid_rsp2 got v=%b d=%h exp v=0100 d=e5", rsp_valid, rsp_data);
    end
    tick;
  endtask

  task automatic test_ports3;
    logic [2:0] exp_g, exp_v;
    logic [7:0] exp_d;
    for (int p = 0; p < 3; p++) req_addr3[p*AW +: AW] = 12'h200 + AW'(p);
    req_valid3 = 3'b111; rsp_ready3 = 3'b111;
    for (int k = 0; k <= 6; k++) begin
      #1;
      exp_g = 3'b001 << (k % 3);
      n_checks++;
      if (req_ready3 !== exp_g || rom_addr3 !== (12'h200 + AW'(k % 3))) begin
        n_errors++; $display("FAIL p3_grant[%0d] got g=%b a=%h exp g=%b", k, req_ready3, rom_addr3, exp_g);
      end
      if (k > 0) begin
        exp_v = 3'b001 << ((k - 1) % 3);
        exp_d = 8'((k - 1) % 3) ^ 8'hA5;
        n_checks++;
        if (rsp_valid3 !== exp_v || rsp_data3 !== exp_d) begin
          n_errors++; $display("FAIL p3_rsp[%0d] got v=%b d=%h exp v=%b d=%h", k, rsp_valid3, rsp_data3, exp_v, exp_d);
        end
      end
      tick;
    end
    req_valid3 = '0;
    tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_fairness;
    test_backpressure;
    test_reset_mid;
    test_ports3;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Round-robin arbiter that shares one synchronous-read ROM port among `PORTS` requesters. Each requester gets a valid/ready request channel and a valid/ready response channel. The arbiter drives the ROM's `en` and `addr` inputs and uses the ROM's registered output as its single-entry response buffer. It sits between the ROM instance and the fetch/lookup units that consume table data.

## Interface

Parameters:
- `WIDTH`, 8: ROM data width.
- `DEPTH`, 4096: ROM depth. `AW = $clog2(DEPTH)`.
- `PORTS`, 4: number of requesters, minimum 2.

Ports (clock and reset first):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  PORTS  request valid, one bit per requester.
- `req_addr`  in  PORTS*AW  flattened request addresses; requester i uses bits `[i*AW +: AW]`.
- `req_ready`  out  PORTS  request accepted, one-hot or zero.
- `rsp_valid`  out  PORTS  response valid, one-hot or zero.
- `rsp_data`  out  WIDTH  response data, shared by all requesters; qualified by `rsp_valid`.
- `rsp_ready`  in  PORTS  response consumed.
- `rom_en`  out  1  ROM read enable.
- `rom_addr`  out  AW  ROM read address.
- `rom_data`  in  WIDTH  ROM registered read data; 1-cycle latency, holds its value while `rom_en`=0.

## Operation

Internal state:
- `pend`: a response is outstanding.
- `owner`: index of the requester that owns the outstanding response.
- `ptr`: round-robin priority pointer.

Rules:
- Free condition: `free = !pend || (rsp_ready[owner])`. A free condition means the buffer is empty, or it is being consumed this cycle.
- Arbitration: search `req_valid` starting at index `ptr`, upward, wrapping modulo PORTS. The first set bit wins (`gnt`).
- `req_ready[gnt] = free && |req_valid`. All other `req_ready` bits are 0. `req_ready` combinationally depends on `req_valid`, so requesters must not make `req_valid` depend on `req_ready`.
- Issue: `rom_en = free && |req_valid` and `rom_addr = req_addr[gnt]`. When not issuing, `rom_en`=0 and `rom_addr` is don't-care (drive 0).
- On issue, at the clock edge:
  - `pend` is set to 1.
  - `owner` is set to `gnt`.
  - `ptr` is set to `(gnt+1) mod PORTS`. The wrap is explicit; PORTS need not be a power of two.
- On consume without a new issue: `pend` is cleared to 0. `ptr` and `owner` are unchanged.
- While `pend` is set and unconsumed: no issue occurs, `rom_en`=0, and the ROM output holds `rsp_data` stable.
- `rsp_valid[i] = pend && (owner == i)`.
- `rsp_data = rom_data`, passed straight through with no extra register.
- `rsp_ready` bits of non-owners are ignored.
- A requester may hold `req_valid` with a changing address until it is accepted. Only the address present in the accept cycle is read.

Reset:
- During `rst`: `pend`=0, `owner`=0, `ptr`=0.
- During `rst`, all `req_ready`=0 and `rom_en`=0; requests are not accepted while `rst` is high.
- `rsp_valid`=0 from the cycle after the reset edge.
- Reset mid-transaction discards the outstanding response with no `rsp_valid` pulse.
- The ROM's own `rst` input is tied 0 by the integrator. It must not be shared with this block's `rst`, because that would zero held data.

## Timing

- Latency: a request accepted at edge t produces `rsp_valid` high in the cycle after t, with `rsp_data = mem[addr]`.
- Throughput: one read per cycle when the owner's `rsp_ready` is held high. Back-to-back grants may go to different requesters.
- Simultaneous consume and issue in the same cycle: the new response replaces the old at the next edge; `pend` stays 1.
- Backpressure: `rsp_valid` and `rsp_data` are stable until `rsp_ready[owner]` is seen high at an edge.
- Fairness: a requester holding `req_valid` waits at most PORTS-1 grants to others.
- Single-requester case: the pointer still rotates. No starvation is possible because the search wraps.

## Test plan

Bench ROM contents: `mem[a] = a[7:0] ^ 8'hA5`. Default parameters.

1. Single read: port 2 requests addr 0x010 with `rsp_ready` high. `req_ready[2]` is high the same cycle; the next cycle shows `rsp_valid`=4'b0100 and `rsp_data`=0xB5; then `rsp_valid` returns to 0.
2. Streaming: port 0 issues addrs 0..7 continuously with `rsp_ready` high. Data 0xA5,0xA4,…,0xA2 appear on 8 consecutive cycles with `rsp_valid[0]` held high throughout.
3. Fairness: all ports valid from reset, `rsp_ready` all high. Grant order is 0,1,2,3,0,1,… Each response appears with the correct owner bit and data.
4. Backpressure: port 1 reads addr 0x0FF and holds `rsp_ready[1]` low for 5 cycles. `rsp_data` holds 0x5A and `rsp_valid[1]` stays high. `rom_en` is 0 and all `req_ready`=0 for those cycles. A waiting port 3 is granted in the cycle `rsp_ready[1]` rises.
5. Reset mid-operation: assert `rst` while port 0's response is pending. `rsp_valid` drops to 0 with no response delivered. After `rst` is released, a request from port 2 with port 0 also valid is granted to port 0 first, because `ptr`=0.
6. Non-power-of-two PORTS=3: all ports continuously valid. Grants follow 0,1,2,0 with no out-of-range index.
